// File: rtl/vram_arbiter.sv
// Arbitrates the single-port VRAM between byte-wide CPU accesses and a video word prefetch
// stream feeding a small show-ahead FIFO; one RAM operation per clock.
module vram_arbiter #(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned URGENT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  input  logic        vid_start,
  input  logic [13:0] vid_base,
  input  logic [13:0] vid_len,
  output logic        vid_valid,
  output logic [15:0] vid_data,
  input  logic        vid_rd,
  output logic        vid_busy,
  output logic [14:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout_byte,
  input  logic [15:0] ram_dout_word
);

  localparam int unsigned Depth = 1 << FIFO_AW;
  localparam int unsigned CntW  = FIFO_AW + 1;
  localparam logic [CntW:0] DepthC  = (CntW + 1)'(Depth);
  localparam logic [CntW:0] UrgentC = (CntW + 1)'(URGENT);

  logic [15:0]        fifo_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q;
  logic [13:0]        word_ptr_q, remaining_q;
  logic               vid_inflight_q;
  logic               cpu_ack_q, cpu_rd_q;
  logic [7:0]         cpu_dout_q, ram_din_q;
  logic [14:0]        ram_addr_q;

  logic [CntW:0] credit;
  logic          vid_elig, cpu_elig, urgent, vid_gnt, cpu_gnt, push, pop;

  // Credit counts both buffered words and the word still on its way back from the RAM.
  always_comb begin
    credit   = {1'b0, count_q} + {{CntW{1'b0}}, vid_inflight_q};
    // No video grant in the vid_start cycle: its return would land in the freshly flushed FIFO.
    vid_elig = rst_n && !vid_start && (remaining_q != 14'd0) && (credit < DepthC);
    cpu_elig = rst_n && cpu_req && !cpu_ack_q;
    urgent   = credit <= UrgentC;
    vid_gnt  = vid_elig && (urgent || !cpu_elig);
    cpu_gnt  = cpu_elig && !(vid_elig && urgent);
    push     = vid_inflight_q && !vid_start;
    pop      = vid_rd && (count_q != '0) && !vid_start;
  end

  always_comb begin
    ram_addr = ram_addr_q;
    ram_we   = 1'b0;
    ram_din  = ram_din_q;
    if (vid_gnt) begin
      ram_addr = {word_ptr_q, 1'b0};
    end else if (cpu_gnt) begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we;
      ram_din  = cpu_din;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign cpu_dout  = cpu_rd_q ? ram_dout_byte : cpu_dout_q;
  assign vid_valid = count_q != '0;
  assign vid_data  = fifo_q[rd_ptr_q];
  assign vid_busy  = (remaining_q != 14'd0) || vid_inflight_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(Depth); i++) fifo_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      word_ptr_q     <= '0;
      remaining_q    <= '0;
      vid_inflight_q <= 1'b0;
      cpu_ack_q      <= 1'b0;
      cpu_rd_q       <= 1'b0;
      cpu_dout_q     <= '0;
      ram_din_q      <= '0;
      ram_addr_q     <= '0;
    end else begin
      cpu_ack_q      <= cpu_gnt;
      cpu_rd_q       <= cpu_gnt && !cpu_we;
      if (cpu_rd_q) cpu_dout_q <= ram_dout_byte;
      ram_addr_q     <= ram_addr;
      ram_din_q      <= ram_din;
      vid_inflight_q <= vid_gnt;
      if (vid_start) begin
        word_ptr_q  <= vid_base;
        remaining_q <= vid_len;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        count_q     <= '0;
      end else begin
        if (vid_gnt) begin
          word_ptr_q  <= word_ptr_q + 14'd1;
          remaining_q <= remaining_q - 14'd1;
        end
        if (push) begin
          fifo_q[wr_ptr_q] <= ram_dout_word;
          wr_ptr_q         <= wr_ptr_q + FIFO_AW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
        if (push && !pop) count_q <= count_q + CntW'(1);
        else if (!push && pop) count_q <= count_q - CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural 32 KB VRAM (byte and word ports, 1-cycle read).
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_din, cpu_dout;
  logic        cpu_ack;
  logic        vid_start;
  logic [13:0] vid_base, vid_len;
  logic        vid_valid, vid_rd, vid_busy;
  logic [15:0] vid_data;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din, ram_dout_byte;
  logic [15:0] ram_dout_word;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [32768];

  vram_arbiter #(.FIFO_AW(2), .URGENT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
    .vid_start(vid_start), .vid_base(vid_base), .vid_len(vid_len),
    .vid_valid(vid_valid), .vid_data(vid_data), .vid_rd(vid_rd), .vid_busy(vid_busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din),
    .ram_dout_byte(ram_dout_byte), .ram_dout_word(ram_dout_word)
  );

  always #5 clk = ~clk;

  // Initial RAM contents: byte at a = a[7:0] ^ a[14:8].
  function automatic logic [7:0] f(input logic [14:0] a);
    return a[7:0] ^ {1'b0, a[14:8]};
  endfunction

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    ram_dout_byte <= mem[ram_addr];
    ram_dout_word <= {mem[{ram_addr[14:1], 1'b1}], mem[{ram_addr[14:1], 1'b0}]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp4 [4];
  logic [14:0] wa;
  int idx, k, reqc, lat;

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = f(15'(i));
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
    vid_start = 1'b0; vid_base = '0; vid_len = '0; vid_rd = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("reset_idle", {ram_we, vid_valid, cpu_ack, vid_busy, ram_addr, cpu_dout, ram_din},
          32'h0);
      cyc();
    end

    // CPU write then read
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'h1235; cpu_din = 8'hA5; #1;
    chk("wr_grant", {ram_we, ram_addr, ram_din, cpu_ack}, {1'b1, 15'h1235, 8'hA5, 1'b0});
    cyc();
    chk("wr_ack", {cpu_ack, ram_we}, {1'b1, 1'b0});
    cpu_req = 1'b0; cyc();
    cpu_req = 1'b1; cpu_we = 1'b0; #1;
    chk("rd_grant", {ram_we, ram_addr, cpu_ack}, {1'b0, 15'h1235, 1'b0});
    cyc();
    chk("rd_ack", {cpu_ack, cpu_dout, ram_we}, {1'b1, 8'hA5, 1'b0});
    cpu_req = 1'b0; cyc();
    chk("rd_hold", {cpu_ack, cpu_dout}, {1'b0, 8'hA5});

    // Video fetch with word-pointer wrap, no pops
    vid_start = 1'b1; vid_base = 14'h3FFE; vid_len = 14'd4; #1;
    chk("vs_no_grant", ram_we, 1'b0);
    cyc(); vid_start = 1'b0; #1;
    chk("vf0", {ram_addr, ram_we, vid_busy}, {15'h7FFC, 1'b0, 1'b1});
    cyc(); chk("vf1", ram_addr, 15'h7FFE);
    cyc(); chk("vf2", ram_addr, 15'h0000);
    cyc(); chk("vf3", ram_addr, 15'h0002);
    cyc(); chk("vf_last_inflight", {vid_busy, ram_we, ram_addr}, {1'b1, 1'b0, 15'h0002});
    cyc(); chk("vf_done", {vid_busy, vid_valid, vid_data}, {1'b0, 1'b1, 16'h8283});
    for (int i = 0; i < 3; i++) begin
      cyc(); chk("vf_stall", {ram_we, ram_addr, vid_valid}, {1'b0, 15'h0002, 1'b1});
    end
    exp4[0] = 16'h8283; exp4[1] = 16'h8081; exp4[2] = 16'h0100; exp4[3] = 16'h0302;
    for (int i = 0; i < 4; i++) begin
      vid_rd = 1'b1; #1;
      chk("vf_pop", {vid_valid, vid_data}, {1'b1, exp4[i]});
      cyc();
    end
    vid_rd = 1'b0; #1;
    chk("vf_empty", {vid_valid, vid_busy}, 2'b00);
    cyc();

    // Priority: CPU shares the vid_start cycle, urgent video beats CPU, then CPU beats video
    vid_start = 1'b1; vid_base = 14'h0200; vid_len = 14'd8;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0020; #1;
    chk("pri_cpu_with_start", {ram_addr, ram_we}, {15'h0020, 1'b0});
    cyc(); vid_start = 1'b0; #1;
    chk("pri_vid_ack_cycle", {ram_addr, cpu_ack, cpu_dout}, {15'h0400, 1'b1, 8'h20});
    cyc(); chk("pri_vid_urgent", {ram_addr, cpu_ack}, {15'h0402, 1'b0});
    cyc(); chk("pri_cpu_nonurgent", {ram_addr, ram_we}, {15'h0020, 1'b0});
    cyc(); chk("pri_vid_after", {ram_addr, cpu_ack, cpu_dout}, {15'h0404, 1'b1, 8'h20});
    cpu_req = 1'b0;
    cyc();
    // Restart while a fetch is in flight and two words are buffered
    chk("rs_pre", {vid_valid, vid_busy}, 2'b11);
    vid_start = 1'b1; vid_base = 14'h0300; vid_len = 14'd2; #1;
    chk("rs_no_grant", {ram_we, ram_addr}, {1'b0, 15'h0404});
    cyc(); vid_start = 1'b0; #1;
    chk("rs_flushed", {vid_valid, ram_addr, vid_busy}, {1'b0, 15'h0600, 1'b1});
    cyc(); chk("rs_f1", {vid_valid, ram_addr}, {1'b0, 15'h0602});
    cyc(); chk("rs_first", {vid_valid, vid_data, vid_busy}, {1'b1, 16'h0706, 1'b1});
    cyc(); chk("rs_idle", vid_busy, 1'b0);
    vid_rd = 1'b1; #1; chk("rs_pop0", vid_data, 16'h0706);
    cyc(); chk("rs_pop1", {vid_valid, vid_data}, {1'b1, 16'h0504});
    cyc(); vid_rd = 1'b0; #1;
    chk("rs_empty", vid_valid, 1'b0);

    // Reset mid-operation abandons fetch and CPU access
    vid_start = 1'b1; vid_base = 14'h0000; vid_len = 14'd8;
    cyc(); vid_start = 1'b0;
    cyc(); cpu_req = 1'b1; cpu_addr = 15'h0050; rst_n = 1'b0; #1;
    chk("rst_gate", ram_we, 1'b0);
    cyc();
    chk("rst_mid", {cpu_ack, vid_busy, vid_valid}, 3'b000);
    rst_n = 1'b1; cpu_req = 1'b0;
    cyc();

    // Streaming with continuous pops and back-to-back CPU reads
    vid_start = 1'b1; vid_base = 14'h1000; vid_len = 14'd16; vid_rd = 1'b1;
    cyc(); vid_start = 1'b0;
    k = 0; idx = 0; reqc = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h4000;
    for (int c = 1; c <= 200 && idx < 16; c++) begin
      cyc();
      if (vid_valid) begin
        wa = 15'h2000 + 15'(2 * idx);
        chk("st_word", vid_data, {f(wa + 15'd1), f(wa)});
        idx++;
      end
      if (cpu_ack) begin
        lat = c - reqc;
        chk("st_cpu_lat_le6", {31'd0, lat <= 6}, 32'd1);
        chk("st_cpu_data", cpu_dout, f(cpu_addr));
        k++;
        cpu_addr = 15'h4000 + 15'(k);
        reqc = c + 1;
      end
    end
    chk("st_count", idx, 16);
    chk("st_cpu_served", {31'd0, k >= 4}, 32'd1);
    cpu_req = 1'b0;
    repeat (2) cyc();
    chk("st_drained", {vid_valid, vid_busy}, 2'b00);
    vid_rd = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
